// File: rtl/vending_pkg.sv
// Shared types and constants for the vending input path: FSM state encoding,
// coin values and the item price table.
package vending_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDone    = 2'd2
  } state_e;

  localparam logic [7:0] CoinVal1  = 8'd1;
  localparam logic [7:0] CoinVal5  = 8'd5;
  localparam logic [7:0] CoinVal10 = 8'd10;
  localparam logic [7:0] CoinVal20 = 8'd20;

  localparam logic [7:0] PriceItem0 = 8'd15;
  localparam logic [7:0] PriceItem1 = 8'd20;
  localparam logic [7:0] PriceItem2 = 8'd25;
  localparam logic [7:0] PriceItem3 = 8'd30;

  function automatic logic [7:0] coin_value(input logic [1:0] coin_type);
    logic [7:0] val;
    unique case (coin_type)
      2'b00:   val = CoinVal1;
      2'b01:   val = CoinVal5;
      2'b10:   val = CoinVal10;
      default: val = CoinVal20;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/price_lut.sv
// Combinational item-to-price lookup.
module price_lut
  import vending_pkg::*;
(
  input  logic [1:0] item_i,
  output logic [7:0] price_o
);

  always_comb begin
    price_o = PriceItem0;
    unique case (item_i)
      2'd0:    price_o = PriceItem0;
      2'd1:    price_o = PriceItem1;
      2'd2:    price_o = PriceItem2;
      default: price_o = PriceItem3;
    endcase
  end

endmodule

// File: rtl/input_handler.sv
// Vending input FSM: collects coins and an item selection, then closes the
// transaction on payment, cancel or idle timeout with a one-cycle end_trans.
module input_handler
  import vending_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       select_valid,
  input  logic [1:0] sel_in,
  input  logic       cancel,
  output logic       end_trans,
  output logic [7:0] sum_money,
  output logic [7:0] price,
  output logic [1:0] item_select,
  output logic       coin_reject,
  output logic       busy
);

  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  price_q, price_d;
  logic [1:0]  item_q, item_d;
  logic        sel_q, sel_d;
  logic [15:0] cnt_q, cnt_d;
  logic        reject_q, reject_d;

  logic [7:0]  lut_price;
  logic [8:0]  coin_sum;
  logic        coin_fits;
  logic        any_event;

  price_lut u_price_lut (
    .item_i  (sel_in),
    .price_o (lut_price)
  );

  // 9-bit sum so an overflowing coin can be detected and refused.
  assign coin_sum  = {1'b0, sum_q} + {1'b0, coin_value(coin_type)};
  assign coin_fits = (coin_sum <= 9'd255);
  assign any_event = coin_valid | select_valid;

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    price_d  = price_q;
    item_d   = item_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    reject_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (coin_valid) begin
          sum_d = coin_sum[7:0];
        end
        if (select_valid) begin
          item_d  = sel_in;
          price_d = lut_price;
          sel_d   = 1'b1;
        end
        if (any_event) begin
          state_d = StCollect;
        end
      end

      StCollect: begin
        if (cancel) begin
          state_d  = StDone;
          price_d  = '0;
          cnt_d    = '0;
          reject_d = coin_valid;
        end else begin
          if (coin_valid) begin
            if (coin_fits) begin
              sum_d = coin_sum[7:0];
            end else begin
              reject_d = 1'b1;
            end
          end
          if (select_valid) begin
            item_d  = sel_in;
            price_d = lut_price;
            sel_d   = 1'b1;
          end
          if (any_event) begin
            cnt_d = '0;
          end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
          // Completion uses the values just updated on this edge.
          if (sel_d && (sum_d >= price_d)) begin
            state_d = StDone;
          end else if (!any_event && (cnt_d >= TimeoutVal)) begin
            if (sum_q == 8'd0) begin
              state_d = StIdle;
              sum_d   = '0;
              price_d = '0;
              item_d  = '0;
              sel_d   = 1'b0;
              cnt_d   = '0;
            end else begin
              state_d = StDone;
              price_d = '0;
            end
          end
        end
      end

      StDone: begin
        reject_d = coin_valid;
        state_d  = StIdle;
        sum_d    = '0;
        price_d  = '0;
        item_d   = '0;
        sel_d    = 1'b0;
        cnt_d    = '0;
      end

      default: begin
        state_d = StIdle;
        sum_d   = '0;
        price_d = '0;
        item_d  = '0;
        sel_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sum_q    <= '0;
      price_q  <= '0;
      item_q   <= '0;
      sel_q    <= 1'b0;
      cnt_q    <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      price_q  <= price_d;
      item_q   <= item_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      reject_q <= reject_d;
    end
  end

  assign end_trans   = (state_q == StDone);
  assign busy        = (state_q != StIdle);
  assign sum_money   = sum_q;
  assign price       = price_q;
  assign item_select = item_q;
  assign coin_reject = reject_q;

endmodule
